serial_tx_fifo: RTL and testbench
=================================

Name: serial_tx_fifo

Overview:
Parametrised memory-mapped UART transmitter; the next generation of the write-only Serial peripheral.
- Sits behind the Mmu on the serial select line and drives one TX pin.
- Adds a TX FIFO, a programmable frame format (data bits, parity, stop bits), a readable status register, a sticky overflow flag and a flush command.

Parameters:
CLK_HZ, 10000000, core clock frequency in Hz
BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer floor, min 1) cycles per bit
FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2

Ports:
clock  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high
sel  input  1  Mmu select for this peripheral
we  input  1  write strobe, qualified by sel
re  input  1  read strobe, qualified by sel
addr  input  32  byte address; only addr[2] decoded
din  input  32  write data
dout  output  32  read data, combinational
tx  output  1  serial line, idle high
busy  output  1  1 while the shifter is not IDLE or the FIFO is non-empty

Behaviour:
Register map:
- addr[2]=0 DATA.
  - Write pushes din[DATA_BITS-1:0].
  - Read returns 0.
- addr[2]=1 STATUS/CTRL.
  - Read fields: bit0 full, bit1 empty, bit2 shifter active, bit3 overflow (sticky), bits[16:8] FIFO count, all other bits 0.
  - Write din[0]=1 flushes the FIFO; the frame in flight completes.
  - Write din[3]=1 clears overflow.
- dout = 0 when sel=0.
- A write occurs when sel & we at the rising edge. re has no side effects; it is reserved for future read-clear fields.

FIFO:
- Circular buffer; pointers wrap modulo FIFO_DEPTH; count register width log2(FIFO_DEPTH)+1.
- Push accepted iff (not full) or (pop in same cycle). A rejected push sets overflow, and data is dropped.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Flush in the same cycle as a push: flush wins, push is dropped, overflow is unaffected.

TX state machine: IDLE, START, DATA, PAR, STOP.
- A bit counter counts 0..DIV-1; each state or bit lasts exactly DIV cycles.
- IDLE:
  - tx=1.
  - If FIFO non-empty: pop into the shift register, go to START next cycle.
  - tx falls on the first START cycle, which is 1 cycle after the pop edge.
- START: tx=0.
- DATA:
  - DATA_BITS bits, LSB first.
  - Afterwards go to PAR if PARITY!=0, else STOP.
- PAR: tx = XOR of data bits (even), inverted for odd.
- STOP:
  - STOP_BITS × DIV cycles, tx=1.
  - At the end: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Frame length in cycles = DIV × (1 + DATA_BITS + (PARITY?1:0) + STOP_BITS).

Reset (asynchronous, immediate, including mid-frame):
- tx=1, busy=0, state IDLE, counters and pointers 0, FIFO empty, overflow=0, dout reflects status empty (0x2 when sel and addr[2]=1).

Test Plan:
Use CLK_HZ=40, BAUD=10 (DIV=4), FIFO_DEPTH=4, 8N1 unless stated.
1. Write DATA 0x55 → tx low for cycles 1-4 after pop, then bits 1,0,1,0,1,0,1,0 each 4 cycles, then high 4 cycles; busy deasserts on cycle 41; STATUS reads 0x00000002.
2. Write 0xA1, 0xB2 back-to-back → two frames, 80 cycles total; second start bit immediately follows first stop bit, with no idle cycle.
3. Write 6 bytes while the shifter is busy → first pops immediately; FIFO fills to 4 (full=1, count=4); sixth write sets overflow; STOP read bit3=1. Write STATUS 0x8 → bit3=0. Only 5 frames appear on tx.
4. PARITY=1, STOP_BITS=2, write 0x07 → 12-bit frame of 48 cycles; parity bit=1; tx high for 8 cycles at the end.
5. Queue 3 bytes, then write STATUS 0x1 mid-first-frame → first frame completes; no further frames; empty=1, count=0.
6. Assert reset mid-DATA between clock edges → tx=1 and busy=0 immediately; after release, STATUS=0x2; a new write transmits a clean full frame.

Source files
------------

// File: rtl/serial_tx_fifo.sv
// Memory-mapped UART transmitter with a TX FIFO, programmable frame format,
// readable status register, sticky overflow flag and flush command.
module serial_tx_fifo #(
    parameter int CLK_HZ     = 10000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        tx,
    output logic        busy
);
    localparam int DIV_RAW = CLK_HZ / BAUD;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // Unused data bits above DATA_BITS are held at zero, so a full-byte XOR is exact.
    function automatic logic frame_parity(input logic [7:0] d);
        return (^d) ^ (PARITY == 2);
    endfunction

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    state_t        state_r, state_n_s;
    logic [DW-1:0] cnt_r, cnt_n_s;
    logic [2:0]    bit_r, bit_n_s;
    logic [7:0]    data_r, data_n_s;
    logic          tx_r, tx_n_s;
    logic          pop_s, push_req_s, push_ok_s, flush_s, ovf_clr_s, ctl_wr_s;
    logic          full_s, empty_s, bit_end_s;
    logic [31:0]   status_s;
    logic          unused_s;

    assign unused_s   = ^{re, addr[31:3], addr[1:0], din};
    assign push_req_s = sel & we & ~addr[2];
    assign ctl_wr_s   = sel & we & addr[2];
    assign flush_s    = ctl_wr_s & din[0];
    assign ovf_clr_s  = ctl_wr_s & din[3];
    assign full_s     = (count_r == CW'(FIFO_DEPTH));
    assign empty_s    = (count_r == CW'(0));
    assign push_ok_s  = push_req_s & (~full_s | pop_s) & ~flush_s;
    assign bit_end_s  = (cnt_r == DIV_LAST);

    // FIFO storage; data only, no reset needed.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din[7:0] & DATA_MASK;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            ovf_r    <= 1'b0;
        end else begin
            if (flush_s) begin
                wr_ptr_r <= AW'(0);
                rd_ptr_r <= AW'(0);
                count_r  <= CW'(0);
            end else begin
                if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
                if (pop_s)     rd_ptr_r <= rd_ptr_r + AW'(1);
                count_r <= count_r + CW'(push_ok_s) - CW'(pop_s);
            end
            if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end else if (push_req_s & ~push_ok_s & ~flush_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Shifter next-state, bit timing, pop request and next line level.
    always_comb begin
        state_n_s = state_r;
        bit_n_s   = bit_r;
        data_n_s  = data_r;
        pop_s     = 1'b0;
        if (state_r == IDLE || bit_end_s) begin
            cnt_n_s = DW'(0);
        end else begin
            cnt_n_s = cnt_r + DW'(1);
        end
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    data_n_s  = mem_r[rd_ptr_r];
                    state_n_s = START;
                end else begin
                    state_n_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_n_s = DATA;
                    bit_n_s   = 3'd0;
                end else begin
                    state_n_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && bit_r == DATA_LAST) begin
                    state_n_s = (PARITY != 0) ? PAR : STOP;
                    bit_n_s   = 3'd0;
                end else if (bit_end_s) begin
                    bit_n_s = bit_r + 3'd1;
                end else begin
                    bit_n_s = bit_r;
                end
            end
            PAR: begin
                if (bit_end_s) begin
                    state_n_s = STOP;
                    bit_n_s   = 3'd0;
                end else begin
                    state_n_s = PAR;
                end
            end
            STOP: begin
                // Back-to-back frames: the next byte is popped on the last stop cycle.
                if (bit_end_s && bit_r == STOP_LAST && !empty_s) begin
                    pop_s     = 1'b1;
                    data_n_s  = mem_r[rd_ptr_r];
                    state_n_s = START;
                end else if (bit_end_s && bit_r == STOP_LAST) begin
                    state_n_s = IDLE;
                end else if (bit_end_s) begin
                    bit_n_s = bit_r + 3'd1;
                end else begin
                    bit_n_s = bit_r;
                end
            end
            default: state_n_s = IDLE;
        endcase
        case (state_n_s)
            IDLE:    tx_n_s = 1'b1;
            START:   tx_n_s = 1'b0;
            DATA:    tx_n_s = data_n_s[bit_n_s];
            PAR:     tx_n_s = frame_parity(data_n_s);
            STOP:    tx_n_s = 1'b1;
            default: tx_n_s = 1'b1;
        endcase
    end

    // Shifter state register and registered line output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= DW'(0);
            bit_r   <= 3'd0;
            data_r  <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            bit_r   <= bit_n_s;
            data_r  <= data_n_s;
            tx_r    <= tx_n_s;
        end
    end

    assign status_s = {15'd0, 9'(count_r), 4'd0, ovf_r, (state_r != IDLE), empty_s, full_s};
    assign dout     = (sel & addr[2]) ? status_s : 32'd0;
    assign tx       = tx_r;
    assign busy     = (state_r != IDLE) | ~empty_s;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: an 8N1 and an 8E2 instance share stimulus and are
// compared each cycle against a frame/queue model, plus literal pin checks.
module tb_serial_tx_fifo;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0, we = 1'b0, re = 1'b0;
    logic [31:0] addr = 32'd0, din = 32'd0;
    logic [31:0] dout_a, dout_b;
    logic        tx_a, tx_b, busy_a, busy_b;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    serial_tx_fifo #(.CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(DEPTH), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1)) dut_a (
        .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
        .addr(addr), .din(din), .dout(dout_a), .tx(tx_a), .busy(busy_a));

    serial_tx_fifo #(.CLK_HZ(40), .BAUD(10), .FIFO_DEPTH(DEPTH), .DATA_BITS(8),
                     .PARITY(1), .STOP_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .sel(sel), .we(we), .re(re),
        .addr(addr), .din(din), .dout(dout_b), .tx(tx_b), .busy(busy_b));

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Model: a byte queue per instance plus the frame currently on the line.
    logic [7:0]  m_q [2][DEPTH];
    int          m_cnt [2];
    int          m_pos [2];
    int          m_len [2];
    bit          m_act [2];
    bit          m_ovf [2];
    logic [15:0] m_frame [2];
    int          par_mode [2] = '{0, 1};
    int          stop_n [2]   = '{1, 2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] build_frame(input logic [7:0] d, input int pm);
        logic [15:0] f;
        f      = 16'hFFFF;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (pm == 1) f[9] = ^d;
        if (pm == 2) f[9] = ~^d;
        return f;
    endfunction

    function automatic logic [31:0] m_status(input int i);
        logic [31:0] s;
        s       = 32'd0;
        s[16:8] = 9'(m_cnt[i]);
        s[3]    = m_ovf[i];
        s[2]    = m_act[i];
        s[1]    = (m_cnt[i] == 0);
        s[0]    = (m_cnt[i] == DEPTH);
        return s;
    endfunction

    task automatic model_step(input int i);
        bit push, ctl;
        push = sel && we && !addr[2];
        ctl  = sel && we && addr[2];
        if (m_act[i]) begin
            if (m_pos[i] == m_len[i] - 1) m_act[i] = 1'b0;
            else m_pos[i]++;
        end
        if (!m_act[i] && m_cnt[i] > 0) begin
            m_frame[i] = build_frame(m_q[i][0], par_mode[i]);
            m_len[i]   = DIV * (9 + ((par_mode[i] != 0) ? 1 : 0) + stop_n[i]);
            for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k + 1];
            m_cnt[i]--;
            m_act[i] = 1'b1;
            m_pos[i] = 0;
        end
        if (push) begin
            if (m_cnt[i] < DEPTH) begin
                m_q[i][m_cnt[i]] = din[7:0];
                m_cnt[i]++;
            end else begin
                m_ovf[i] = 1'b1;
            end
        end
        if (ctl) begin
            if (din[0]) m_cnt[i] = 0;
            if (din[3]) m_ovf[i] = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cnt[i] = 0;
                m_pos[i] = 0;
                m_len[i] = 0;
                m_act[i] = 1'b0;
                m_ovf[i] = 1'b0;
            end else begin
                model_step(i);
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            logic        e_tx, e_busy;
            logic [31:0] e_dout;
            e_tx   = m_act[i] ? m_frame[i][m_pos[i] / DIV] : 1'b1;
            e_busy = m_act[i] || (m_cnt[i] != 0);
            e_dout = (sel && addr[2]) ? m_status(i) : 32'd0;
            check(i == 0 ? "tx_a" : "tx_b", (i == 0) ? tx_a : tx_b, e_tx);
            check(i == 0 ? "busy_a" : "busy_b", (i == 0) ? busy_a : busy_b, e_busy);
            check(i == 0 ? "dout_a" : "dout_b", (i == 0) ? dout_a : dout_b, e_dout);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic a2, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = {29'd0, a2, 2'd0}; din = d;
        tick();
        sel = 1'b0; we = 1'b0; addr = 32'd0; din = 32'd0;
    endtask

    task automatic rd_status(input string name, input logic [31:0] ea, input logic [31:0] eb);
        sel = 1'b1; re = 1'b1; addr = 32'h4;
        #1;
        check({name, "_a"}, dout_a, ea);
        check({name, "_b"}, dout_b, eb);
        sel = 1'b0; re = 1'b0; addr = 32'd0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < limit) begin
            tick();
            n++;
        end
        check("idle_timeout", {31'd0, busy_a | busy_b}, 32'd0);
    endtask

    task automatic frame_len_a(input string name, input int pop_cyc, input int exp_len);
        int n;
        n = 0;
        while (busy_a && n < 400) begin
            tick();
            n++;
        end
        check(name, cyc - pop_cyc, exp_len);
    endtask

    initial begin
        logic [9:0]  frame55;
        logic [11:0] frame07;
        int          p;
        frame55 = 10'b1_01010101_0;
        frame07 = 12'b11_1_00000111_0;

        repeat (3) tick();
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        #2 reset = 1'b0;
        tick();
        rd_status("rst_status", 32'h2, 32'h2);

        // Single 8N1 frame of 0x55.
        wr(1'b0, 32'h55);
        tick();
        for (int k = 1; k <= 40; k++) begin
            check("t1_tx", tx_a, frame55[(k - 1) / DIV]);
            tick();
        end
        check("t1_busy_end", busy_a, 1'b0);
        rd_status("t1_status", 32'h2, 32'h6);
        wait_idle(100);

        // Back-to-back frames with no idle gap.
        wr(1'b0, 32'hA1);
        wr(1'b0, 32'hB2);
        for (int k = 1; k <= 81; k++) begin
            if (k == 40) check("t2_stop1", tx_a, 1'b1);
            if (k == 41) check("t2_start2", tx_a, 1'b0);
            if (k == 80) check("t2_busy80", busy_a, 1'b1);
            if (k == 81) check("t2_busy81", busy_a, 1'b0);
            tick();
        end
        wait_idle(100);

        // Overflow: six writes, four queued plus one in flight.
        wr(1'b0, 32'h31);
        p = cyc + 1;
        for (int k = 2; k <= 6; k++) wr(1'b0, 32'h30 + k);
        rd_status("t3_full", 32'h40D, 32'h40D);
        wr(1'b1, 32'h8);
        rd_status("t3_ovf_clr", 32'h405, 32'h405);
        frame_len_a("t3_five_frames", p, 200);
        wait_idle(300);

        // 8E2 frame of 0x07 on the second instance.
        wr(1'b0, 32'h07);
        tick();
        for (int k = 1; k <= 48; k++) begin
            check("t4_tx", tx_b, frame07[(k - 1) / DIV]);
            tick();
        end
        check("t4_busy_end", busy_b, 1'b0);
        wait_idle(100);

        // Flush during the first frame.
        wr(1'b0, 32'h11);
        p = cyc + 1;
        wr(1'b0, 32'h22);
        wr(1'b0, 32'h33);
        repeat (8) tick();
        wr(1'b1, 32'h1);
        rd_status("t5_flushed", 32'h6, 32'h6);
        frame_len_a("t5_one_frame", p, 40);
        wait_idle(100);

        // Asynchronous reset mid-frame.
        wr(1'b0, 32'h5A);
        repeat (12) tick();
        #2 reset = 1'b1;
        #1;
        check("t6_tx_a", tx_a, 1'b1);
        check("t6_tx_b", tx_b, 1'b1);
        check("t6_busy_a", busy_a, 1'b0);
        check("t6_busy_b", busy_b, 1'b0);
        tick();
        #2 reset = 1'b0;
        rd_status("t6_status", 32'h2, 32'h2);
        tick();
        wr(1'b0, 32'hC3);
        p = cyc + 1;
        frame_len_a("t6_clean_frame", p, 40);
        wait_idle(100);

        // Randomised traffic: dense then sparse writes, occasional flush/clear.
        for (int n = 0; n < 800; n++) begin
            sel     = ($urandom_range(0, 3) != 0);
            we      = ($urandom_range(0, (n < 400) ? 7 : 39) == 0);
            re      = 1'($urandom_range(0, 1));
            addr    = $urandom;
            addr[2] = ($urandom_range(0, 7) == 0);
            din     = $urandom;
            din[0]  = ($urandom_range(0, 5) == 0);
            tick();
        end
        sel = 1'b0; we = 1'b0; re = 1'b0; addr = 32'd0; din = 32'd0;
        wait_idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
